wgt_bram_writer: RTL and testbench

WGT_BRAM_WRITER -- requirements
Module: wgt_bram_writer

---
 rtl/gat_pkg.sv | 13 +
 rtl/wgt_bram_writer.sv | 129 ++++++++++++
 tb/tb_wgt_bram_writer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gat_pkg.sv
// Shared GAT package: writer FSM states and default weight-buffer geometry.
package gat_pkg;

    localparam int GAT_DATA_WIDTH = 8;
    localparam int GAT_WGT_DEPTH  = 16 * 1433;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wbw_state_e;

endpackage : gat_pkg

// File: rtl/wgt_bram_writer.sv
// Streams DEPTH weight elements into BRAM port A at sequential addresses.
// Define WGT_BRAM_WRITER_CHECKSUM_EN to add a 16-bit running sum output.
module wgt_bram_writer
    import gat_pkg::*;
#(
    parameter  int DATA_WIDTH = GAT_DATA_WIDTH,
    parameter  int DEPTH      = GAT_WGT_DEPTH,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_vld_i,
    output logic                  s_rdy_o,
    output logic                  wgt_bram_ena,
    output logic                  wgt_bram_wea,
    output logic [ADDR_W-1:0]     wgt_bram_addra,
    output logic [DATA_WIDTH-1:0] wgt_bram_dina,
    output logic                  wgt_bram_load_done,
    output logic                  busy_o
`ifdef WGT_BRAM_WRITER_CHECKSUM_EN
    ,
    output logic [15:0]           checksum_o
`endif
);

    wbw_state_e            state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic                  wr_vld_q, wr_vld_d;
    logic                  wr_last_q, wr_last_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  xfer;
    logic                  last_beat;

    assign s_rdy_o   = (state_q == LOAD);
    assign busy_o    = (state_q == LOAD);
    // A restart pulse discards any beat presented in the same cycle.
    assign xfer      = s_vld_i && s_rdy_o && !start_i;
    assign last_beat = (ptr_q == ADDR_W'(DEPTH - 1));

    always_comb begin
        // NOTE: every variable gets a default first, so no branch can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_vld_d  = 1'b0;
        wr_last_d = 1'b0;
        wr_addr_d = '0;
        wr_data_d = '0;
        done_d    = done_q;

        if (wr_vld_q && wr_last_q) done_d = 1'b1;
        if (start_i)               done_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                if (start_i) begin
                    ptr_d = '0;
                end else if (xfer) begin
                    wr_vld_d  = 1'b1;
                    wr_last_d = last_beat;
                    wr_addr_d = ptr_q;
                    wr_data_d = s_data_i;
                    if (last_beat) begin
                        state_d = DONE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            wr_vld_q  <= 1'b0;
            wr_last_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_vld_q  <= wr_vld_d;
            wr_last_q <= wr_last_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // Address and data registers are zeroed on idle cycles, so the port reads 0 when not writing.
    assign wgt_bram_ena       = wr_vld_q;
    assign wgt_bram_wea       = wr_vld_q;
    assign wgt_bram_addra     = wr_addr_q;
    assign wgt_bram_dina      = wr_data_q;
    assign wgt_bram_load_done = done_q;

`ifdef WGT_BRAM_WRITER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (wr_vld_q) sum_d = sum_q + 16'(wr_data_q);
        if (start_i)  sum_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign checksum_o = sum_q;
`endif

endmodule : wgt_bram_writer

// File: tb/tb_wgt_bram_writer.sv
// Self-checking bench for wgt_bram_writer (DEPTH=4, DATA_WIDTH=8) with a cycle-level reference model.
module tb_wgt_bram_writer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [DW-1:0] s_data_i;
    logic          s_vld_i;
    logic          s_rdy_o;
    logic          ena, wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          load_done;
    logic          busy_o;
`ifdef WGT_BRAM_WRITER_CHECKSUM_EN
    logic [15:0]   checksum_o;
`endif

    wgt_bram_writer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start_i),
        .s_data_i           (s_data_i),
        .s_vld_i            (s_vld_i),
        .s_rdy_o            (s_rdy_o),
        .wgt_bram_ena       (ena),
        .wgt_bram_wea       (wea),
        .wgt_bram_addra     (addra),
        .wgt_bram_dina      (dina),
        .wgt_bram_load_done (load_done),
        .busy_o             (busy_o)
`ifdef WGT_BRAM_WRITER_CHECKSUM_EN
        ,
        .checksum_o         (checksum_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: what the outputs must show during the current cycle.
    bit            m_loading;
    int            m_ptr;
    bit            m_wr_vld;
    int            m_wr_addr;
    logic [DW-1:0] m_wr_data;
    bit            m_done;
    int            m_sum;
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] obs_mem [DEPTH];
    int            obs_writes;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_loading = 1'b0;
        m_ptr     = 0;
        m_wr_vld  = 1'b0;
        m_wr_addr = 0;
        m_wr_data = '0;
        m_done    = 1'b0;
        m_sum     = 0;
    endfunction

    function automatic void model_step(input logic st, input logic vld, input logic [DW-1:0] d);
        bit accept;
        accept = m_loading && vld && !st;
        if (st)                                     m_done = 1'b0;
        else if (m_wr_vld && m_wr_addr == DEPTH-1)  m_done = 1'b1;
        if (st)            m_sum = 0;
        else if (m_wr_vld) m_sum = (m_sum + int'(m_wr_data)) % 65536;
        m_wr_vld  = accept;
        m_wr_addr = accept ? m_ptr : 0;
        m_wr_data = accept ? d : '0;
        if (accept) exp_mem[m_ptr] = d;
        if (st) begin
            m_loading = 1'b1;
            m_ptr     = 0;
        end else if (accept) begin
            if (m_ptr == DEPTH-1) m_loading = 1'b0;
            m_ptr++;
        end
    endfunction

    task automatic check_outputs();
        check($sformatf("c%0d s_rdy_o", cyc),   32'(s_rdy_o),   32'(m_loading));
        check($sformatf("c%0d busy_o", cyc),    32'(busy_o),    32'(m_loading));
        check($sformatf("c%0d ena", cyc),       32'(ena),       32'(m_wr_vld));
        check($sformatf("c%0d wea", cyc),       32'(wea),       32'(m_wr_vld));
        check($sformatf("c%0d addra", cyc),     32'(addra),     m_wr_addr);
        check($sformatf("c%0d dina", cyc),      32'(dina),      32'(m_wr_data));
        check($sformatf("c%0d load_done", cyc), 32'(load_done), 32'(m_done));
`ifdef WGT_BRAM_WRITER_CHECKSUM_EN
        if (m_done) check($sformatf("c%0d checksum_o", cyc), 32'(checksum_o), m_sum);
`endif
        if (ena === 1'b1) begin
            obs_writes++;
            obs_mem[addra] = dina;
        end
    endtask

    // Check this cycle's outputs, then drive inputs for the coming rising edge.
    task automatic tick(input logic st, input logic vld, input logic [DW-1:0] d);
        check_outputs();
        start_i  = st;
        s_vld_i  = vld;
        s_data_i = d;
        model_step(st, vld, d);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start_i  = 1'b0;
        s_vld_i  = 1'b0;
        s_data_i = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            exp_mem[i] = '0;
            obs_mem[i] = '0;
        end
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // No writes after reset until start, even with valid data offered.
        obs_writes = 0;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'h77);
        check("post-reset writes", obs_writes, 0);

        // Basic back-to-back load, then start from DONE.
        obs_writes = 0;
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, 8'(8'h11 * (i + 1)));
        drain(3);
        check("basic writes", obs_writes, 4);
        for (int i = 0; i < DEPTH; i++) check($sformatf("basic mem%0d", i), 32'(obs_mem[i]), 32'(8'h11 * (i + 1)));
        check("basic done level", 32'(load_done), 1);
        tick(1'b1, 1'b0, '0);
        check("done cleared by start", 32'(load_done), 0);

        // Stalls: valid toggles 1,0,1,0.
        obs_writes = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b0, 1'b1, 8'(8'hA0 + i));
            tick(1'b0, 1'b0, 8'hEE);
        end
        drain(2);
        check("stall writes", obs_writes, 4);
        for (int i = 0; i < DEPTH; i++) check($sformatf("stall mem%0d", i), 32'(obs_mem[i]), 32'(8'hA0 + i));

        // Overflow: a fifth beat must be refused.
        obs_writes = 0;
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, 8'(8'hD0 + i));
        check("overflow rdy", 32'(s_rdy_o), 0);
        tick(1'b0, 1'b1, 8'h55);
        drain(2);
        check("overflow writes", obs_writes, 4);
        for (int i = 0; i < DEPTH; i++) check($sformatf("overflow mem%0d", i), 32'(obs_mem[i]), 32'(8'hD0 + i));

        // Mid-load restart: beat in the restart cycle is discarded.
        obs_writes = 0;
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, 8'hC0);
        tick(1'b0, 1'b1, 8'hC1);
        tick(1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("restart done low %0d", i), 32'(load_done), 0);
            tick(1'b0, 1'b1, 8'(8'hB0 + i));
        end
        drain(2);
        check("restart writes", obs_writes, 6);
        for (int i = 0; i < DEPTH; i++) check($sformatf("restart mem%0d", i), 32'(obs_mem[i]), 32'(8'hB0 + i));

`ifdef WGT_BRAM_WRITER_CHECKSUM_EN
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, 8'hFF);
        drain(2);
        check("checksum ff x4", 32'(checksum_o), 32'h03FC);
`endif

        // Mid-load asynchronous reset after three beats.
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'(8'h60 + i));
        check_outputs();
        #2 rst_n = 1'b0;
        #1;
        check("rst s_rdy_o",   32'(s_rdy_o),   0);
        check("rst busy_o",    32'(busy_o),    0);
        check("rst ena",       32'(ena),       0);
        check("rst wea",       32'(wea),       0);
        check("rst addra",     32'(addra),     0);
        check("rst dina",      32'(dina),      0);
        check("rst load_done", 32'(load_done), 0);
        model_reset();
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        obs_writes = 0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'h99);
        check("post mid-reset writes", obs_writes, 0);

        // Randomized loads with stalls and occasional restarts.
        for (int l = 0; l < 4; l++) begin
            tick(1'b1, 1'b0, '0);
            for (int k = 0; k < 30; k++)
                tick($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
            drain(2);
            for (int i = 0; i < DEPTH; i++)
                check($sformatf("rand%0d mem%0d", l, i), 32'(obs_mem[i]), 32'(exp_mem[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wgt_bram_writer
